// File: rtl/timer_irq_source.sv
// timer_irq_source: memory-mapped interval timer that drives the IRQ line of the control unit.
// Register window (decoded on Address[31:4]): 0x0 TH reload, 0x4 TL counter, 0x8 TCON, 0xC PSC.
// Optional feature macro: TIMER_PRESCALE_EN adds the 16-bit PSC register and tick prescaler;
// without it the timer ticks every cycle while EN=1 and offset 0xC reads 0.
//
// IRQ handshake: IRQ acts as "valid" and PC31 (kernel mode) as "ready". A request is raised
// when ST becomes 1 (PEND). It is taken when PC31 is seen high in PEND (-> SERV), and IRQ is
// masked combinationally by PC31 so it drops in the same cycle. Software retires the request
// by writing TCON with ST cleared (SERV -> IDLE). A clearing write in PEND abandons it.
module timer_irq_source #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic        PC31,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } state_t;

  // Debug view of the handshake FSM and the timing events, for bound checkers.
  typedef struct packed {
    state_t state;
    logic   tick;
    logic   ovf;
  } timer_dbg_t;

  state_t     state;
  state_t     state_next;
  timer_dbg_t dbg;

  logic [31:0] th;
  logic [31:0] tl;
  logic        en;
  logic        ie;
  logic        st;
  logic        ovr;
  logic        st_next;
  logic        ovr_next;

  logic        sel;
  logic        wr_th;
  logic        wr_tl;
  logic        wr_tcon;
  logic        tick;
  logic        ovf;
  logic        unused_bits;

  assign sel     = (Address[31:4] == BASE_ADDR[31:4]);
  assign wr_th   = MemWr & sel & (Address[3:2] == 2'd0);
  assign wr_tl   = MemWr & sel & (Address[3:2] == 2'd1);
  assign wr_tcon = MemWr & sel & (Address[3:2] == 2'd2);

`ifdef TIMER_PRESCALE_EN
  logic [15:0] psc;
  logic [15:0] pcnt;
  logic        wr_psc;

  assign wr_psc = MemWr & sel & (Address[3:2] == 2'd3);
  assign tick   = en & (pcnt == psc);

  // Prescaler: counts 0..PSC while enabled, restarts on a PSC write, holds while EN=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      psc  <= 16'h0;
      pcnt <= 16'h0;
    end else if (wr_psc) begin
      psc  <= WriteData[15:0];
      pcnt <= 16'h0;
    end else if (en) begin
      pcnt <= (pcnt == psc) ? 16'h0 : pcnt + 16'h1;
    end
  end
`else
  assign tick = en;
`endif

  // A TL write in a tick cycle replaces the count, so no overflow is taken from the old value.
  assign ovf = tick & (tl == 32'hFFFF_FFFF) & ~wr_tl;

  assign dbg         = '{state: state, tick: tick, ovf: ovf};
  assign unused_bits = ^{Address[1:0], dbg};

  // Status flags: software may only clear ST/OVR; an enabled overflow sets them and wins.
  always_comb begin
    st_next  = st;
    ovr_next = ovr;
    if (wr_tcon) begin
      st_next  = st & WriteData[2];
      ovr_next = ovr & WriteData[3];
    end
    if (ovf & ie) begin
      st_next = 1'b1;
      if (st) ovr_next = 1'b1;
    end
  end

  // Timer registers: bus writes take priority over counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      th  <= 32'h0;
      tl  <= 32'h0;
      en  <= 1'b0;
      ie  <= 1'b0;
      st  <= 1'b0;
      ovr <= 1'b0;
    end else begin
      if (wr_th) th <= WriteData;
      if (wr_tl) tl <= WriteData;
      else if (tick) tl <= (tl == 32'hFFFF_FFFF) ? th : tl + 32'h1;
      if (wr_tcon) begin
        en <= WriteData[0];
        ie <= WriteData[1];
      end
      st  <= st_next;
      ovr <= ovr_next;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Handshake next state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (st_next) state_next = PEND;
      PEND: begin
        if (!st_next)  state_next = IDLE;
        else if (PC31) state_next = SERV;
      end
      SERV: if (wr_tcon & ~st_next) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake output: request is masked in kernel mode and when IE is off.
  always_comb begin
    IRQ = (state == PEND) & ~PC31 & ie;
  end

  // Zero-latency read mux; unselected or idle bus reads return zero.
  always_comb begin
    ReadData = 32'h0;
    if (MemRd & sel) begin
      case (Address[3:2])
        2'd0: ReadData = th;
        2'd1: ReadData = tl;
        2'd2: ReadData = {28'h0, ovr, st, ie, en};
`ifdef TIMER_PRESCALE_EN
        2'd3: ReadData = {16'h0, psc};
`else
        2'd3: ReadData = 32'h0;
`endif
        default: ReadData = 32'h0;
      endcase
    end
  end

endmodule
